rr_lock_arbiter: RTL

//   N-way round-robin arbiter with packet lock, for VC/switch allocation in the VC-based routers.

---
 rtl/rr_lock_arbiter_pkg.sv | 14 +
 rtl/rr_lock_arbiter_prio_pick.sv | 19 +
 rtl/rr_lock_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/rr_lock_arbiter_pkg.sv
// Shared definitions for the round-robin lock arbiter and its priority picker.
package rr_lock_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_st_e;

  // Width of a binary index into n requesters; never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_prio_pick.sv
// Cyclic priority select: first set req bit at or above the one-hot ptr, wrapping N-1 -> 0.
module rr_prio_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] gnt
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_gnt;

  // Borrow from ptr ripples up through zero req bits and stops at the first set one;
  // the upper copy supplies the end-around carry for winners below ptr.
  assign dbl_req = {req, req};
  assign dbl_gnt = dbl_req & ~(dbl_req - {{N{1'b0}}, ptr});
  assign gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter that holds the grant from a packet head to its tail transfer.
module rr_lock_arbiter
  import rr_lock_arbiter_pkg::*;
#(
  parameter  int N       = 8,
  parameter  bit LOCK_EN = 1'b1,
  localparam int IDW     = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req,
  input  logic           last,
  input  logic           ready,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           any_grant,
  output logic           locked
);

  // Handshake: a flit moves when any_grant & ready in the same cycle; grant is
  // offered without waiting for ready and stays put while ready=0 and req is stable.

  arb_st_e      st_q, st_d;
  logic [N-1:0] ptr_q, ptr_d;
  logic [N-1:0] owner_q, owner_d;
  logic [N-1:0] pick_gnt;
  logic [N-1:0] grant_raw;
  logic         transfer;

  function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[(i + 1) % N] = v[i];
    return r;
  endfunction

  rr_prio_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt)
  );

  assign grant_raw = (st_q == ST_LOCKED) ? (owner_q & req) : pick_gnt;
  assign grant     = rstn ? grant_raw : '0;
  assign any_grant = |grant;
  assign locked    = rstn & (st_q == ST_LOCKED);
  assign transfer  = any_grant & ready;

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_id = grant_id | IDW'(i);
    end
  end

  always_comb begin
    st_d    = st_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (transfer) begin
      case (st_q)
        ST_IDLE: begin
          if (last || !LOCK_EN) begin
            ptr_d = rotl1(grant);
          end else begin
            st_d    = ST_LOCKED;
            owner_d = grant;
          end
        end
        ST_LOCKED: begin
          if (last) begin
            st_d    = ST_IDLE;
            owner_d = '0;
            ptr_d   = rotl1(owner_q);
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q    <= ST_IDLE;
      ptr_q   <= N'(1);
      owner_q <= '0;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  a_ptr_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot(ptr_q));
  a_owner_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(owner_q));

endmodule
